// File: rtl/axi_slave_read.sv
// Purpose : AXI4 read-channel slave (AR/R) serving FIXED/INCR/WRAP bursts from a 1-cycle SRAM read port.
// Latency : first mem_rd_en 1 cycle after the AR handshake, first RVALID 3 cycles after it, then 1 beat/cycle.
// Backpres: a 2-entry output buffer plus an in-flight credit stops SRAM reads while RREADY stalls; no data is lost.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   S_AXI_AR*                     read address channel (one burst accepted at a time)
//   S_AXI_R*                      read data channel, driven from the buffer head
//   mem_rd_en/addr/data           SRAM read port; data is valid the cycle after mem_rd_en
module axi_slave_read #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int MEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               S_AXI_ARVALID,
    input  logic [ADDR_WD-1:0] S_AXI_ARADDR,
    input  logic [7:0]         S_AXI_ARLEN,
    input  logic [2:0]         S_AXI_ARSIZE,
    input  logic [1:0]         S_AXI_ARBURST,
    output logic               S_AXI_ARREADY,
    output logic               S_AXI_RVALID,
    output logic [DATA_WD-1:0] S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RLAST,
    input  logic               S_AXI_RREADY,
    output logic               mem_rd_en,
    output logic [MEM_AW-1:0]  mem_rd_addr,
    input  logic [DATA_WD-1:0] mem_rd_data
);
    localparam int ADDRLSB = $clog2(DATA_WD / 8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nxt;
    logic               ready_q;      // holds ARREADY low for the cycle right after reset
    logic [ADDR_WD-1:0] addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic [1:0]         err_resp;
    logic [8:0]         beats_left;
    logic [7:0]         pop_cnt;
    logic               inflight;     // a read issued last cycle lands in the buffer this cycle

    logic [DATA_WD-1:0] fifo_dat [2];
    logic [1:0]         fifo_resp [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         fifo_cnt;

    logic               ar_hs, rvalid, pop, last_pop, issue, push;
    logic [2:0]         credit_eff;
    logic               decerr, slverr;
    logic [ADDR_WD-1:0] n_bytes, wrap_mask, addr_nxt;

    assign S_AXI_ARREADY = (state == IDLE) && ready_q;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    assign rvalid   = (fifo_cnt != 2'd0);
    assign pop      = rvalid && S_AXI_RREADY;
    assign last_pop = pop && (pop_cnt == len);
    assign push     = inflight;

    // A slot freed by this cycle's pop can be reused by the read issued now.
    assign credit_eff = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == BURST) && (beats_left != 9'd0) && (credit_eff < 3'd2);

    // Error bursts walk the same credit path but never touch the SRAM.
    assign mem_rd_en   = issue && (err_resp == RESP_OKAY);
    assign mem_rd_addr = addr[ADDRLSB +: MEM_AW];

    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RDATA  = rvalid ? fifo_dat[rd_ptr]  : '0;
    assign S_AXI_RRESP  = rvalid ? fifo_resp[rd_ptr] : RESP_OKAY;
    assign S_AXI_RLAST  = rvalid && (pop_cnt == len);

    // Error classification of the incoming request; DECERR wins over SLVERR.
    assign decerr = ((S_AXI_ARADDR >> (ADDRLSB + MEM_AW)) != '0);
    assign slverr = (S_AXI_ARBURST == 2'b11)
                 || (int'(S_AXI_ARSIZE) > ADDRLSB)
                 || ((S_AXI_ARBURST == 2'b10) &&
                     !((S_AXI_ARLEN == 8'd1) || (S_AXI_ARLEN == 8'd3) ||
                       (S_AXI_ARLEN == 8'd7) || (S_AXI_ARLEN == 8'd15)));

    // Next beat address. WRAP bound = (len+1)*n, a power of two for legal lengths.
    always_comb begin
        n_bytes   = ADDR_WD'(1) << size;
        wrap_mask = ((ADDR_WD'(len) + ADDR_WD'(1)) << size) - ADDR_WD'(1);
        addr_nxt  = addr;
        case (burst)
            2'b01:   addr_nxt = (addr & ~(n_bytes - ADDR_WD'(1))) + n_bytes;
            2'b10:   addr_nxt = (addr & ~wrap_mask) | ((addr + n_bytes) & wrap_mask);
            default: addr_nxt = addr;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs)    state_nxt = BURST;
            BURST:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_q  <= 1'b1;
            inflight <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            len        <= '0;
            size       <= '0;
            burst      <= '0;
            err_resp   <= RESP_OKAY;
            beats_left <= '0;
            pop_cnt    <= '0;
        end else if (ar_hs) begin
            addr       <= S_AXI_ARADDR;
            len        <= S_AXI_ARLEN;
            size       <= S_AXI_ARSIZE;
            burst      <= S_AXI_ARBURST;
            err_resp   <= decerr ? RESP_DECERR : (slverr ? RESP_SLVERR : RESP_OKAY);
            beats_left <= {1'b0, S_AXI_ARLEN} + 9'd1;
            pop_cnt    <= '0;
        end else begin
            if (issue) begin
                beats_left <= beats_left - 9'd1;
                addr       <= addr_nxt;
            end
            if (pop) pop_cnt <= pop_cnt + 8'd1;
        end
    end

    // 2-entry output buffer; push and pop may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr]  <= (err_resp == RESP_OKAY) ? mem_rd_data : '0;
            fifo_resp[wr_ptr] <= err_resp;
        end
    end
endmodule
